// File: rtl/shared_mem_arbiter.sv
// Arbiter that shares one single-port synchronous memory between the
// instruction-fetch port (IF) and the data-memory port (DM).
// Only one transaction is in flight at a time. DM has priority, but after
// STARVE_MAX consecutive DM grants with IF waiting, IF gets the next slot.
// Grants are decided combinationally in IDLE and on the completion cycle of
// an access, so accesses can issue back to back.
module shared_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                flush,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                if_stall,
    output logic                mem_stall
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STK_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_MAX);

    typedef enum logic { ST_IDLE, ST_WAIT } state_t;
    typedef enum logic { OWN_IF,  OWN_DM  } owner_t;

    state_t           state_q,   state_d;
    owner_t           owner_q,   owner_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [STK_W-1:0] streak_q,  streak_d;
    logic             discard_q, discard_d;
    logic             wr_q,      wr_d;      // outstanding DM access is a write

    logic busy;
    logic done;
    logic arb_en;
    logic if_win;

    // Arbitration: DM first unless IF has waited through STARVE_MAX DM grants.
    always_comb begin
        busy   = (state_q == ST_WAIT);
        done   = busy && (cnt_q == '0);
        arb_en = RST_N && (!busy || done);
        if_win = if_req && !flush && (!dm_req || (streak_q == STK_MAX));
        if_gnt = arb_en && if_win;
        dm_gnt = arb_en && dm_req && !if_win;
    end

    // Memory strobe and fields follow the winner; everything is 0 when idle.
    always_comb begin
        mem_en    = if_gnt || dm_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_be    = '1;
            mem_addr  = if_addr;
        end
    end

    // Completion pulses, returned data and pipeline stalls.
    always_comb begin
        if_rvalid = RST_N && done && (owner_q == OWN_IF) && !discard_q && !flush;
        dm_rvalid = RST_N && done && (owner_q == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = (dm_rvalid && !wr_q) ? mem_rdata : '0;
        if_stall  = RST_N && ((if_req && !if_gnt && !flush) ||
                              (busy && !done && (owner_q == OWN_IF)));
        mem_stall = RST_N && ((dm_req && !dm_gnt) ||
                              (busy && !done && (owner_q == OWN_DM)));
    end

    // Next-state: latency countdown, ownership, squash flag and IF starvation streak.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        streak_d  = streak_q;
        discard_d = discard_q;
        wr_d      = wr_q;

        if (busy && !done) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (done) begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
        end else if (busy && (owner_q == OWN_IF) && flush) begin
            discard_d = 1'b1;
        end

        if (if_gnt || dm_gnt) begin
            state_d   = ST_WAIT;
            cnt_d     = CNT_INIT;
            owner_d   = if_gnt ? OWN_IF : OWN_DM;
            wr_d      = dm_gnt && dm_we;
            discard_d = 1'b0;
        end

        if (arb_en) begin
            if (if_gnt || !if_req) begin
                streak_d = '0;
            end else if (dm_gnt && (streak_q != STK_MAX)) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            cnt_q     <= '0;
            streak_q  <= '0;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            discard_q <= discard_d;
            wr_q      <= wr_d;
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each
// with its own request queues, memory image and reference model. A single
// process steps the clock, checks every output every cycle against the model,
// and runs directed scenarios with hand-computed literal expectations.
module tb_shared_mem_arbiter;

    localparam int NI   = 2;
    localparam int TR   = 2048;
    localparam int SMAX = 4;
    localparam int QN   = 32;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT connections
    logic        rst_n     [NI] = '{1'b0, 1'b0};
    logic        flush     [NI] = '{1'b0, 1'b0};
    logic        if_req    [NI] = '{1'b0, 1'b0};
    logic [31:0] if_addr   [NI] = '{32'h0, 32'h0};
    logic        dm_req    [NI] = '{1'b0, 1'b0};
    logic        dm_we     [NI] = '{1'b0, 1'b0};
    logic [3:0]  dm_be     [NI] = '{4'h0, 4'h0};
    logic [31:0] dm_addr   [NI] = '{32'h0, 32'h0};
    logic [31:0] dm_wdata  [NI] = '{32'h0, 32'h0};
    logic [31:0] mem_rdata [NI] = '{32'h0, 32'h0};
    logic        if_gnt    [NI];
    logic        if_rvalid [NI];
    logic [31:0] if_rdata  [NI];
    logic        dm_gnt    [NI];
    logic        dm_rvalid [NI];
    logic [31:0] dm_rdata  [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [3:0]  mem_be    [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic        if_stall  [NI];
    logic        mem_stall [NI];

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            shared_mem_arbiter #(
                .ADDR_W    (32),
                .DATA_W    (32),
                .MEM_LAT   ((gi == 0) ? 1 : 3),
                .STARVE_MAX(SMAX)
            ) u_dut (
                .CLK      (clk),
                .RST_N    (rst_n[gi]),
                .flush    (flush[gi]),
                .if_req   (if_req[gi]),
                .if_addr  (if_addr[gi]),
                .if_gnt   (if_gnt[gi]),
                .if_rvalid(if_rvalid[gi]),
                .if_rdata (if_rdata[gi]),
                .dm_req   (dm_req[gi]),
                .dm_we    (dm_we[gi]),
                .dm_be    (dm_be[gi]),
                .dm_addr  (dm_addr[gi]),
                .dm_wdata (dm_wdata[gi]),
                .dm_gnt   (dm_gnt[gi]),
                .dm_rvalid(dm_rvalid[gi]),
                .dm_rdata (dm_rdata[gi]),
                .mem_en   (mem_en[gi]),
                .mem_we   (mem_we[gi]),
                .mem_be   (mem_be[gi]),
                .mem_addr (mem_addr[gi]),
                .mem_wdata(mem_wdata[gi]),
                .mem_rdata(mem_rdata[gi]),
                .if_stall (if_stall[gi]),
                .mem_stall(mem_stall[gi])
            );
        end
    endgenerate

    // Bench state (all written by the main process only)
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] iq [NI][QN];
    req_t        dq [NI][QN];
    int          iq_head [NI] = '{0, 0};
    int          iq_tail [NI] = '{0, 0};
    int          dq_head [NI] = '{0, 0};
    int          dq_tail [NI] = '{0, 0};
    logic [31:0] img [NI][4096];
    logic [31:0] slot_d   [NI][8];
    int          slot_due [NI][8];
    // reference model: one outstanding access described by its due cycle
    logic        m_busy   [NI] = '{1'b0, 1'b0};
    int          m_done   [NI] = '{0, 0};
    logic        m_port   [NI] = '{1'b0, 1'b0};  // 0 = IF, 1 = DM
    logic        m_wr     [NI] = '{1'b0, 1'b0};
    logic        m_sq     [NI] = '{1'b0, 1'b0};
    logic [31:0] m_data   [NI] = '{32'h0, 32'h0};
    int          m_streak [NI] = '{0, 0};
    // observed trace, indexed by cycle
    logic [1:0]  tr_gnt [NI][TR];   // 0 none, 1 IF, 2 DM
    logic        tr_ifs [NI][TR];
    logic        tr_mst [NI][TR];
    logic        tr_ifv [NI][TR];
    logic        tr_dmv [NI][TR];
    logic [31:0] tr_ifd [NI][TR];
    logic [31:0] tr_dmd [NI][TR];
    logic        tr_mwe [NI][TR];
    logic [3:0]  tr_mbe [NI][TR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_if(input int k, input logic [31:0] a);
        iq[k][iq_tail[k]] = a;
        iq_tail[k]++;
    endtask

    task automatic push_dm(input int k, input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd);
        dq[k][dq_tail[k]] = '{we: we, be: be, addr: a, wdata: wd};
        dq_tail[k]++;
    endtask

    // Model the cycle, compare, log, and act as the memory for instance k.
    task automatic eval_inst(input int k);
        int lat;
        logic done, can_arb, pi, pd, e_ifv, e_dmv, e_en, e_we, e_ifs, e_mst;
        logic [3:0]  e_be;
        logic [31:0] e_ifd, e_dmd, e_addr, e_wd;
        logic [139:0] act, exp;
        int sidx;
        lat = (k == 0) ? 1 : 3;
        act = {if_gnt[k], if_rvalid[k], dm_gnt[k], dm_rvalid[k], mem_en[k], mem_we[k],
               if_stall[k], mem_stall[k], mem_be[k], if_rdata[k], dm_rdata[k],
               mem_addr[k], mem_wdata[k]};
        if (!rst_n[k]) begin
            exp         = '0;
            m_busy[k]   = 1'b0;
            m_sq[k]     = 1'b0;
            m_streak[k] = 0;
        end else begin
            done    = m_busy[k] && (cyc == m_done[k]);
            can_arb = !m_busy[k] || done;
            e_ifv   = done && !m_port[k] && !m_sq[k] && !flush[k];
            e_dmv   = done && m_port[k];
            e_ifd   = e_ifv ? m_data[k] : 32'h0;
            e_dmd   = (e_dmv && !m_wr[k]) ? m_data[k] : 32'h0;
            pi      = can_arb && if_req[k] && !flush[k] && (!dm_req[k] || m_streak[k] == SMAX);
            pd      = can_arb && dm_req[k] && !pi;
            e_en    = pi || pd;
            e_we    = pd && dm_we[k];
            e_be    = pd ? dm_be[k] : (pi ? 4'hF : 4'h0);
            e_addr  = pd ? dm_addr[k] : (pi ? if_addr[k] : 32'h0);
            e_wd    = pd ? dm_wdata[k] : 32'h0;
            e_ifs   = (if_req[k] && !pi && !flush[k]) || (m_busy[k] && !done && !m_port[k]);
            e_mst   = (dm_req[k] && !pd) || (m_busy[k] && !done && m_port[k]);
            exp = {pi, e_ifv, pd, e_dmv, e_en, e_we, e_ifs, e_mst, e_be, e_ifd, e_dmd, e_addr, e_wd};
            if (can_arb) begin
                if (pi || !if_req[k]) m_streak[k] = 0;
                else if (pd && m_streak[k] < SMAX) m_streak[k] = m_streak[k] + 1;
            end
            if (done) begin
                m_busy[k] = 1'b0;
                m_sq[k]   = 1'b0;
            end else if (m_busy[k] && !m_port[k] && flush[k]) begin
                m_sq[k] = 1'b1;
            end
            if (e_en) begin
                m_busy[k] = 1'b1;
                m_port[k] = pd;
                m_done[k] = cyc + lat;
                m_wr[k]   = e_we;
                m_data[k] = img[k][e_addr[13:2]];
                m_sq[k]   = 1'b0;
            end
        end
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle_outputs[%0d] c=%0d got %h want %h", k, cyc, act, exp);
        end
        if (cyc < TR) begin
            tr_gnt[k][cyc] = if_gnt[k] ? 2'd1 : (dm_gnt[k] ? 2'd2 : 2'd0);
            tr_ifs[k][cyc] = if_stall[k];
            tr_mst[k][cyc] = mem_stall[k];
            tr_ifv[k][cyc] = if_rvalid[k];
            tr_dmv[k][cyc] = dm_rvalid[k];
            tr_ifd[k][cyc] = if_rdata[k];
            tr_dmd[k][cyc] = dm_rdata[k];
            tr_mwe[k][cyc] = mem_we[k];
            tr_mbe[k][cyc] = mem_be[k];
        end
        if (if_req[k] && if_gnt[k] === 1'b1) iq_head[k]++;
        if (dm_req[k] && dm_gnt[k] === 1'b1) dq_head[k]++;
        if (mem_en[k] === 1'b1) begin
            $display("[lat%0d] c=%0d %s addr=%h we=%0d be=%b wdata=%h", lat, cyc,
                     if_gnt[k] ? "IF" : "DM", mem_addr[k], mem_we[k], mem_be[k], mem_wdata[k]);
            if (mem_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[k][b]) img[k][mem_addr[k][13:2]][8*b +: 8] = mem_wdata[k][8*b +: 8];
            end else begin
                sidx = (cyc + lat) % 8;
                slot_d[k][sidx]   = img[k][mem_addr[k][13:2]];
                slot_due[k][sidx] = cyc + lat;
            end
        end
    endtask

    // One clock cycle: present requests, check at negedge, then advance.
    task automatic step();
        for (int k = 0; k < NI; k++) begin
            if_req[k]   = (iq_head[k] != iq_tail[k]);
            if_addr[k]  = if_req[k] ? iq[k][iq_head[k]] : 32'h0;
            dm_req[k]   = (dq_head[k] != dq_tail[k]);
            dm_we[k]    = dm_req[k] ? dq[k][dq_head[k]].we    : 1'b0;
            dm_be[k]    = dm_req[k] ? dq[k][dq_head[k]].be    : 4'h0;
            dm_addr[k]  = dm_req[k] ? dq[k][dq_head[k]].addr  : 32'h0;
            dm_wdata[k] = dm_req[k] ? dq[k][dq_head[k]].wdata : 32'h0;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) eval_inst(k);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (slot_due[k][cyc % 8] == cyc) mem_rdata[k] = slot_d[k][cyc % 8];
            else                             mem_rdata[k] = 32'hBAD0_0000 ^ 32'(cyc);
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((iq_head[k] != iq_tail[k] || dq_head[k] != dq_tail[k] || m_busy[k]) && n < 60) begin
            step();
            n++;
        end
        total++;
        if (n >= 60) begin
            bad++;
            $display("FAIL idle_timeout[%0d]: got busy after %0d cycles want idle", k, n);
        end
    endtask

    logic [31:0] exp_if [3];
    logic [1:0]  exp_pat [7];
    int m;

    initial begin
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 4096; w++) img[k][w] = 32'h5000_0000 | 32'(w);
            img[k][32'h100 >> 2]  = 32'h0000_000A;
            img[k][32'h104 >> 2]  = 32'h0000_000B;
            img[k][32'h108 >> 2]  = 32'h0000_000C;
            img[k][32'h2000 >> 2] = 32'h1234_5678;
            img[k][32'h3000 >> 2] = 32'h1122_3344;
            for (int s = 0; s < 8; s++) slot_due[k][s] = -1;
        end
        exp_if  = '{32'hA, 32'hB, 32'hC};
        exp_pat = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2};

        // 1: reset with both requests pending, then DM wins first
        for (int k = 0; k < NI; k++) begin
            push_if(k, 32'h100);
            push_dm(k, 1'b0, 4'hF, 32'h2000, 32'h0);
        end
        step();
        step();
        for (int k = 0; k < NI; k++) begin
            chk("t1_reset_gnt", 32'(tr_gnt[k][1]), 32'd0);
            chk("t1_reset_stall", {31'd0, tr_ifs[k][1] | tr_mst[k][1]}, 32'd0);
        end
        m = cyc;
        rst_n = '{1'b1, 1'b1};
        wait_idle(0);
        wait_idle(1);
        chk("t1_first_dm_l1", 32'(tr_gnt[0][m]), 32'd2);
        chk("t1_first_dm_l3", 32'(tr_gnt[1][m]), 32'd2);
        chk("t1_dm_data", tr_dmd[0][m + 1], 32'h1234_5678);

        // 2: back-to-back fetch, MEM_LAT=1
        m = cyc;
        push_if(0, 32'h100);
        push_if(0, 32'h104);
        push_if(0, 32'h108);
        wait_idle(0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_if_gnt", 32'(tr_gnt[0][m + i]), 32'd1);
            chk("t2_if_rvalid", {31'd0, tr_ifv[0][m + i + 1]}, 32'd1);
            chk("t2_if_rdata", tr_ifd[0][m + i + 1], exp_if[i]);
        end
        for (int i = 0; i < 4; i++) chk("t2_if_stall", {31'd0, tr_ifs[0][m + i]}, 32'd0);

        // 3: contention, DM first then IF
        m = cyc;
        push_if(0, 32'h104);
        push_dm(0, 1'b0, 4'hF, 32'h2000, 32'h0);
        wait_idle(0);
        chk("t3_dm_first", 32'(tr_gnt[0][m]), 32'd2);
        chk("t3_if_stall", {31'd0, tr_ifs[0][m]}, 32'd1);
        chk("t3_if_next", 32'(tr_gnt[0][m + 1]), 32'd1);
        chk("t3_dm_rdata", tr_dmd[0][m + 1], 32'h1234_5678);
        chk("t3_if_rdata", tr_ifd[0][m + 2], 32'hB);

        // 4: starvation guard, STARVE_MAX=4
        m = cyc;
        for (int i = 0; i < 6; i++) push_dm(0, 1'b0, 4'hF, 32'h2000 + 32'(4 * i), 32'h0);
        push_if(0, 32'h108);
        wait_idle(0);
        for (int i = 0; i < 7; i++) chk("t4_pattern", 32'(tr_gnt[0][m + i]), 32'(exp_pat[i]));
        chk("t4_if_rdata", tr_ifd[0][m + 5], 32'hC);

        // 5: flush squashes an outstanding fetch, MEM_LAT=3
        m = cyc;
        push_if(1, 32'h108);
        step();
        flush[1] = 1'b1;
        push_dm(1, 1'b0, 4'hF, 32'h2000, 32'h0);
        step();
        flush[1] = 1'b0;
        wait_idle(1);
        chk("t5_if_gnt", 32'(tr_gnt[1][m]), 32'd1);
        chk("t5_mem_stall", {31'd0, tr_mst[1][m + 1]}, 32'd1);
        chk("t5_no_if_rvalid", {31'd0, tr_ifv[1][m + 3]}, 32'd0);
        chk("t5_dm_gnt", 32'(tr_gnt[1][m + 3]), 32'd2);
        chk("t5_dm_rvalid", {31'd0, tr_dmv[1][m + 6]}, 32'd1);
        chk("t5_dm_rdata", tr_dmd[1][m + 6], 32'h1234_5678);

        // 6a: byte-enabled write completion
        m = cyc;
        push_dm(0, 1'b1, 4'b0011, 32'h3000, 32'hDEAD_BEEF);
        wait_idle(0);
        chk("t6_dm_gnt", 32'(tr_gnt[0][m]), 32'd2);
        chk("t6_mem_we", {31'd0, tr_mwe[0][m]}, 32'd1);
        chk("t6_mem_be", {28'd0, tr_mbe[0][m]}, 32'h3);
        chk("t6_dm_rvalid", {31'd0, tr_dmv[0][m + 1]}, 32'd1);
        chk("t6_dm_rdata", tr_dmd[0][m + 1], 32'h0);
        chk("t6_mem_word", img[0][32'h3000 >> 2], 32'h1122_BEEF);

        // 6b: reset while a write is outstanding, MEM_LAT=3
        m = cyc;
        push_dm(1, 1'b1, 4'b0011, 32'h3000, 32'hDEAD_BEEF);
        step();
        rst_n[1] = 1'b0;
        step();
        rst_n[1] = 1'b1;
        push_dm(1, 1'b0, 4'hF, 32'h2000, 32'h0);
        wait_idle(1);
        chk("t6r_dm_gnt", 32'(tr_gnt[1][m]), 32'd2);
        chk("t6r_idle_gnt", 32'(tr_gnt[1][m + 2]), 32'd2);
        for (int i = 1; i < 5; i++) chk("t6r_no_rvalid", {31'd0, tr_dmv[1][m + i]}, 32'd0);
        chk("t6r_read_rvalid", {31'd0, tr_dmv[1][m + 5]}, 32'd1);
        chk("t6r_read_rdata", tr_dmd[1][m + 5], 32'h1234_5678);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
